timestamp_counter_sched: RTL and testbench
==========================================

// Module: timestamp_counter_sched
// PURPOSE
//  Free-running system timestamp counter: parametrised width, programmable step, pause and immediate load.
//  Adds scheduled (time-triggered) reload and NUM_CMP compare channels that pulse at programmed times.
//  Sits in TimeController; its counter is the time base for all timed-event sequencers.
// PARAMETERS
//  CNT_W    64  counter, load, target widths (bits)
//  STEP_W   8   increment step width; step 0 is legal and holds the count
//  NUM_CMP  4   number of compare channels (1..16)
// PORTS
//  clk             in   1                    clock
//  reset           in   1                    synchronous, active-high
//  start           in   1                    level: count enable
//  pause           in   1                    level: overrides start, holds count
//  step            in   STEP_W               increment added per counting cycle
//  load_en         in   1                    immediate load pulse
//  load_value      in   CNT_W                value for load_en
//  sched_arm       in   1                    pulse: arm scheduled reload
//  sched_time      in   CNT_W                trigger time for scheduled reload
//  sched_value     in   CNT_W                value loaded at trigger
//  sched_pending   out  1                    scheduled reload armed, not yet fired
//  cmp_wr          in   1                    pulse: program and arm one compare channel
//  cmp_idx         in   $clog2(NUM_CMP)      channel written by cmp_wr
//  cmp_target      in   CNT_W                target time for that channel
//  cmp_armed       out  NUM_CMP              per-channel armed flag
//  cmp_hit         out  NUM_CMP              per-channel one-cycle hit pulse
//  counter         out  CNT_W                registered count
//  running         out  1                    start & ~pause, registered
//  wrap            out  1                    one-cycle pulse: increment overflowed
// BEHAVIOUR
//  - Reset: counter=0, running=0, wrap=0, sched_pending=0, all cmp_armed=0, all cmp_hit=0, all targets=0.
//  - Counter update priority per cycle: reset > load_en > scheduled fire > increment > hold.
//  - Increment: when start & ~pause, counter <= counter + zero-extended step, mod 2^CNT_W.
//    wrap=1 the next cycle iff the CNT_W+1-bit sum carries out. Loads never assert wrap.
//  - load_en: counter <= load_value next cycle; also clears sched_pending (cancels pending reload).
//  - sched_arm: captures sched_time/sched_value and sets sched_pending.
//    A re-arm while pending overwrites the pending reload.
//    sched_arm + load_en in the same cycle: load executes, arm is kept (pending=1, new values).
//  - Scheduled fire: evaluated on registered counter, independent of start/pause.
//    Condition: sched_pending & counter >= sched_time (unsigned).
//    Next cycle: counter <= sched_value, pending <= 0.
//    Arm with sched_time <= current counter fires on the cycle after arming.
//  - Compare ch i: cmp_wr with cmp_idx=i stores target and sets armed.
//    cmp_idx >= NUM_CMP is ignored.
//    Hit condition: armed & counter >= target (unsigned), evaluated on registered counter.
//    cmp_hit[i] pulses for 1 cycle in the following cycle; armed clears in the same edge.
//    Latency: counter reaching target at edge N -> cmp_hit high during cycle N+1.
//    cmp_wr to ch i in the hit-detect cycle: the write wins; re-armed with new target, no pulse.
//    Loads and wraps do not disarm; a load to >= target fires pending channels per the rule above.
//    Multiple channels may hit in the same cycle.
//  - running = registered (start & ~pause); step=0 with running=1 holds count, no wrap.
//  - Reset mid-operation: all state returns to reset values the next cycle; pending arms discarded.
// STRUCTURE
//  - Package timestamp_pkg: TS_CNT_W default, ts_t = logic [TS_CNT_W-1:0],
//    cmp_idx_t, compare-channel struct {armed, target}.
//  - Sub-module ts_compare_channel (target reg, armed flag, hit pulse), instantiated NUM_CMP times.
//    Top decodes cmp_idx into per-channel write enables.
//  - Top holds counter, step adder with carry, sched registers and update-priority mux.
// TESTING
//  1 reset; start=1, step=1, 10 cycles -> counter=10, running=1, wrap=0; pause=1 -> holds 10.
//  2 load 64'hFFFF_FFFF_FFFF_FFFE, step=3 -> next counter=1, wrap pulse exactly 1 cycle.
//  3 counter=100, step=1, sched_arm time=105 value=1000 -> counter 105 then 1000; pending 1->0.
//  4 sched_arm time=200 then load_en 50 before fire -> counter=50, pending=0, no reload at 200.
//  5 ch2 target=20, ch0 target=20, step=4 from 0 -> both hit once in cycle after counter=20; armed=0.
//  6 cmp_wr ch1 target=5 with counter=30 -> hit next cycle.
//    Rewrite ch1 in its detect cycle with target=99 -> no pulse, re-armed.
//  7 reset asserted with sched pending and 3 channels armed -> all flags 0 next cycle, no hits.

Source files
------------

// File: rtl/timestamp_pkg.sv
// Shared types and defaults for the timestamp counter and its compare channels.
package timestamp_pkg;

    localparam int TS_CNT_W   = 64;
    localparam int TS_NUM_CMP = 4;

    typedef logic [TS_CNT_W-1:0]           ts_t;
    typedef logic [$clog2(TS_NUM_CMP)-1:0] cmp_idx_t;

    typedef struct packed {
        logic armed;
        ts_t  target;
    } cmp_chan_t;

endpackage

// File: rtl/ts_compare_channel.sv
// One compare channel: target register, armed flag and a one-cycle hit pulse
// raised the cycle after the registered counter reaches the target.
module ts_compare_channel
    import timestamp_pkg::*;
#(
    parameter int CNT_W = TS_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_target,
    input  logic [CNT_W-1:0] counter,
    output logic             armed,
    output logic             hit,
    output logic [CNT_W-1:0] target
);

    logic fire;

    assign fire = armed && (counter >= target);

    always_ff @(posedge clk) begin
        if (reset) begin
            armed  <= 1'b0;
            hit    <= 1'b0;
            target <= '0;
        end else begin
            // A write in the detect cycle re-arms and suppresses the pulse.
            hit <= fire && !wr;
            if (wr) begin
                target <= wr_target;
                armed  <= 1'b1;
            end else if (fire) begin
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/timestamp_counter_sched.sv
// Free-running timestamp counter with step/pause, immediate load, one scheduled
// reload and NUM_CMP compare channels that pulse at programmed times.
module timestamp_counter_sched
    import timestamp_pkg::*;
#(
    parameter int CNT_W   = TS_CNT_W,
    parameter int STEP_W  = 8,
    parameter int NUM_CMP = TS_NUM_CMP,
    localparam int IDX_W  = (NUM_CMP > 1) ? $clog2(NUM_CMP) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic [STEP_W-1:0]  step,
    input  logic               load_en,
    input  logic [CNT_W-1:0]   load_value,
    input  logic               sched_arm,
    input  logic [CNT_W-1:0]   sched_time,
    input  logic [CNT_W-1:0]   sched_value,
    output logic               sched_pending,
    input  logic               cmp_wr,
    input  logic [IDX_W-1:0]   cmp_idx,
    input  logic [CNT_W-1:0]   cmp_target,
    output logic [NUM_CMP-1:0] cmp_armed,
    output logic [NUM_CMP-1:0] cmp_hit,
    output logic [CNT_W-1:0]   counter,
    output logic               running,
    output logic               wrap
);

    logic [CNT_W:0]       sum;
    logic                 count_en;
    logic                 sched_fire;
    logic [CNT_W-1:0]     sched_time_q;
    logic [CNT_W-1:0]     sched_value_q;
    logic [NUM_CMP-1:0]   ch_wr;
    logic [CNT_W-1:0]     ch_target [NUM_CMP];

    assign count_en   = start && !pause;
    assign sum        = {1'b0, counter} + {{(CNT_W + 1 - STEP_W){1'b0}}, step};
    assign sched_fire = sched_pending && (counter >= sched_time_q);

    always_comb begin
        ch_wr = '0;
        for (int i = 0; i < NUM_CMP; i++) begin
            if (cmp_wr && (int'(cmp_idx) == i)) ch_wr[i] = 1'b1;
        end
    end

    // Update priority: load_en > scheduled fire > increment > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter       <= '0;
            running       <= 1'b0;
            wrap          <= 1'b0;
            sched_pending <= 1'b0;
            sched_time_q  <= '0;
            sched_value_q <= '0;
        end else begin
            running <= count_en;
            wrap    <= 1'b0;
            if (load_en) begin
                counter <= load_value;
            end else if (sched_fire) begin
                counter <= sched_value_q;
            end else if (count_en) begin
                counter <= sum[CNT_W-1:0];
                wrap    <= sum[CNT_W];
            end

            if (sched_arm) begin
                sched_time_q  <= sched_time;
                sched_value_q <= sched_value;
                sched_pending <= 1'b1;
            end else if (load_en || sched_fire) begin
                sched_pending <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CMP; g++) begin : g_ch
        ts_compare_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .wr        (ch_wr[g]),
            .wr_target (cmp_target),
            .counter   (counter),
            .armed     (cmp_armed[g]),
            .hit       (cmp_hit[g]),
            .target    (ch_target[g])
        );
    end

endmodule

// File: tb/tb_timestamp_counter_sched.sv
// Directed scenarios for timestamp_counter_sched with a queue-based scoreboard.
module tb_timestamp_counter_sched;

    logic        clk = 1'b0;
    logic        reset, start, pause, load_en, sched_arm, cmp_wr;
    logic [7:0]  step;
    logic [63:0] load_value, sched_time, sched_value, cmp_target, counter;
    logic [1:0]  cmp_idx;
    logic [3:0]  cmp_armed, cmp_hit;
    logic        sched_pending, running, wrap;

    logic [63:0] exp_q[$];
    logic [63:0] exp;
    int total = 0;
    int bad   = 0;

    timestamp_counter_sched dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .step(step),
        .load_en(load_en), .load_value(load_value),
        .sched_arm(sched_arm), .sched_time(sched_time), .sched_value(sched_value),
        .sched_pending(sched_pending),
        .cmp_wr(cmp_wr), .cmp_idx(cmp_idx), .cmp_target(cmp_target),
        .cmp_armed(cmp_armed), .cmp_hit(cmp_hit),
        .counter(counter), .running(running), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] v);
        load_en = 1'b1; load_value = v;
        tick();
        load_en = 1'b0;
    endtask

    task automatic do_cmp_wr(input int idx, input logic [63:0] t);
        cmp_wr = 1'b1; cmp_idx = 2'(idx); cmp_target = t;
        tick();
        cmp_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        exp_q.push_back(64'd0);
        exp = exp_q.pop_front();
        total++;
        if (counter !== exp) begin bad++; $display("FAIL reset_counter got=%0d exp=%0d", counter, exp); end
        total++;
        if ({running, wrap, sched_pending, cmp_armed, cmp_hit} !== 11'd0) begin
            bad++; $display("FAIL reset_flags got=%b exp=0", {running, wrap, sched_pending, cmp_armed, cmp_hit});
        end
    endtask

    task automatic test_count_pause();
        start = 1'b1; step = 8'd1;
        exp_q.push_back(64'd10);
        repeat (10) tick();
        exp = exp_q.pop_front();
        total++;
        if (counter !== exp || running !== 1'b1 || wrap !== 1'b0) begin
            bad++; $display("FAIL count10 got=%0d run=%b wrap=%b exp=%0d run=1 wrap=0", counter, running, wrap, exp);
        end
        pause = 1'b1;
        exp_q.push_back(64'd10);
        exp_q.push_back(64'd10);
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = exp_q.pop_front();
            total++;
            if (counter !== exp || running !== 1'b0) begin
                bad++; $display("FAIL pause_hold got=%0d run=%b exp=%0d run=0", counter, running, exp);
            end
        end
        pause = 1'b0;
    endtask

    task automatic test_step_zero();
        step = 8'd0;
        exp_q.push_back(64'd10);
        tick(); tick();
        exp = exp_q.pop_front();
        total++;
        if (counter !== exp || running !== 1'b1 || wrap !== 1'b0) begin
            bad++; $display("FAIL step_zero got=%0d run=%b wrap=%b exp=%0d", counter, running, wrap, exp);
        end
    endtask

    task automatic test_wrap();
        step = 8'd3;
        do_load(64'hFFFF_FFFF_FFFF_FFFE);
        total++;
        if (counter !== 64'hFFFF_FFFF_FFFF_FFFE || wrap !== 1'b0) begin
            bad++; $display("FAIL wrap_load got=%h wrap=%b exp=fffffffffffffffe wrap=0", counter, wrap);
        end
        exp_q.push_back({63'd1, 1'b1});
        exp_q.push_back({63'd4, 1'b0});
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = exp_q.pop_front();
            total++;
            if (counter !== {1'b0, exp[63:1]} || wrap !== exp[0]) begin
                bad++; $display("FAIL wrap_pulse got=%0d wrap=%b exp=%0d wrap=%b", counter, wrap, exp[63:1], exp[0]);
            end
        end
    endtask

    task automatic test_sched_fire();
        step = 8'd1;
        do_load(64'd100);
        sched_arm = 1'b1; sched_time = 64'd105; sched_value = 64'd1000;
        tick();
        sched_arm = 1'b0;
        total++;
        if (counter !== 64'd101 || sched_pending !== 1'b1) begin
            bad++; $display("FAIL sched_arm got=%0d pend=%b exp=101 pend=1", counter, sched_pending);
        end
        for (int v = 102; v <= 105; v++) exp_q.push_back(64'(v));
        exp_q.push_back(64'd1000);
        exp_q.push_back(64'd1001);
        for (int i = 0; i < 6; i++) begin
            tick();
            exp = exp_q.pop_front();
            total++;
            if (counter !== exp || sched_pending !== (i < 4)) begin
                bad++; $display("FAIL sched_seq got=%0d pend=%b exp=%0d pend=%b", counter, sched_pending, exp, i < 4);
            end
        end
    endtask

    task automatic test_sched_cancel();
        do_load(64'd150);
        sched_arm = 1'b1; sched_time = 64'd200; sched_value = 64'd7;
        tick();
        sched_arm = 1'b0;
        do_load(64'd50);
        total++;
        if (counter !== 64'd50 || sched_pending !== 1'b0) begin
            bad++; $display("FAIL sched_cancel got=%0d pend=%b exp=50 pend=0", counter, sched_pending);
        end
        exp_q.push_back(64'd210);
        repeat (160) tick();
        exp = exp_q.pop_front();
        total++;
        if (counter !== exp) begin bad++; $display("FAIL sched_no_fire got=%0d exp=%0d", counter, exp); end
    endtask

    task automatic test_cmp_multi();
        start = 1'b0;
        do_load(64'd0);
        do_cmp_wr(2, 64'd20);
        do_cmp_wr(0, 64'd20);
        total++;
        if (cmp_armed !== 4'b0101) begin bad++; $display("FAIL cmp_arm got=%b exp=0101", cmp_armed); end
        start = 1'b1; step = 8'd4;
        for (int i = 1; i <= 7; i++) exp_q.push_back({56'd0, (i == 6) ? 4'b0101 : 4'b0000, (i >= 6) ? 4'b0000 : 4'b0101});
        for (int i = 1; i <= 7; i++) begin
            tick();
            exp = exp_q.pop_front();
            total++;
            if (cmp_hit !== exp[7:4] || cmp_armed !== exp[3:0]) begin
                bad++; $display("FAIL cmp_multi i=%0d got hit=%b armed=%b exp hit=%b armed=%b", i, cmp_hit, cmp_armed, exp[7:4], exp[3:0]);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_cmp_rewrite();
        do_load(64'd30);
        do_cmp_wr(1, 64'd5);
        exp_q.push_back({56'd0, 4'b0010, 4'b0000});
        tick();
        exp = exp_q.pop_front();
        total++;
        if (cmp_hit !== exp[7:4] || cmp_armed !== exp[3:0]) begin
            bad++; $display("FAIL cmp_past_target got hit=%b armed=%b exp hit=%b armed=%b", cmp_hit, cmp_armed, exp[7:4], exp[3:0]);
        end
        do_cmp_wr(1, 64'd5);
        do_cmp_wr(1, 64'd99);
        exp_q.push_back({56'd0, 4'b0000, 4'b0010});
        exp_q.push_back({56'd0, 4'b0000, 4'b0010});
        for (int i = 0; i < 2; i++) begin
            exp = exp_q.pop_front();
            total++;
            if (cmp_hit !== exp[7:4] || cmp_armed !== exp[3:0]) begin
                bad++; $display("FAIL cmp_rewrite i=%0d got hit=%b armed=%b exp hit=%b armed=%b", i, cmp_hit, cmp_armed, exp[7:4], exp[3:0]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        sched_arm = 1'b1; sched_time = 64'd1000; sched_value = 64'd3;
        tick();
        sched_arm = 1'b0;
        do_cmp_wr(0, 64'd500);
        do_cmp_wr(2, 64'd600);
        total++;
        if (sched_pending !== 1'b1 || cmp_armed !== 4'b0111) begin
            bad++; $display("FAIL pre_reset got pend=%b armed=%b exp pend=1 armed=0111", sched_pending, cmp_armed);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.push_back(64'd0);
        exp = exp_q.pop_front();
        total++;
        if ({60'd0, sched_pending, running, wrap} !== exp[62:0] || counter !== exp || cmp_armed !== 4'd0 || cmp_hit !== 4'd0) begin
            bad++; $display("FAIL reset_mid got cnt=%0d pend=%b armed=%b hit=%b exp all 0", counter, sched_pending, cmp_armed, cmp_hit);
        end
        tick();
        total++;
        if (cmp_hit !== 4'd0 || counter !== 64'd0) begin
            bad++; $display("FAIL after_reset got cnt=%0d hit=%b exp 0", counter, cmp_hit);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; step = 8'd0;
        load_en = 1'b0; load_value = '0;
        sched_arm = 1'b0; sched_time = '0; sched_value = '0;
        cmp_wr = 1'b0; cmp_idx = '0; cmp_target = '0;
        test_reset();
        test_count_pause();
        test_step_zero();
        test_wrap();
        test_sched_fire();
        test_sched_cancel();
        test_cmp_multi();
        test_cmp_rewrite();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
